// File: rtl/ahb_uart_cmd_master.sv
// rtl/ahb_uart_cmd_master.sv - UART byte-command to single-word AHB-Lite master (optional timeout: AHB_UART_CMD_MASTER_TIMEOUT_EN)
module ahb_uart_cmd_master #(
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic        cpu_clk,
  input  logic        pwrup_rst_n,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic [31:0] haddr,
  output logic [1:0]  htrans,
  output logic        hwrite,
  output logic [2:0]  hsize,
  output logic [2:0]  hburst,
  output logic [3:0]  hprot,
  output logic [31:0] hwdata,
  input  logic [31:0] hrdata,
  input  logic        hready,
  input  logic        hresp,
  output logic        busy
);

  localparam logic [2:0] ST_CMD      = 3'd0;
  localparam logic [2:0] ST_ADDR_RX  = 3'd1;
  localparam logic [2:0] ST_DATA_RX  = 3'd2;
  localparam logic [2:0] ST_AHB_ADDR = 3'd3;
  localparam logic [2:0] ST_AHB_DATA = 3'd4;
  localparam logic [2:0] ST_RESP     = 3'd5;
  localparam logic [2:0] ST_RDATA_TX = 3'd6;

  localparam logic [7:0] CH_W = 8'h57;
  localparam logic [7:0] CH_R = 8'h52;
  localparam logic [7:0] CH_K = 8'h4B;
  localparam logic [7:0] CH_E = 8'h45;
  localparam logic [7:0] CH_Q = 8'h3F;

  logic [2:0]  state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        is_write_q, is_write_d;
  logic        rd_follow_q, rd_follow_d;
  logic [7:0]  resp_q, resp_d;
  logic        rx_fire, tx_fire;

`ifdef AHB_UART_CMD_MASTER_TIMEOUT_EN
  localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYCLES - 1);
  logic [31:0] to_cnt_q, to_cnt_d;
`endif

  assign rx_ready = (state_q == ST_CMD) || (state_q == ST_ADDR_RX) || (state_q == ST_DATA_RX);
  assign tx_valid = (state_q == ST_RESP) || (state_q == ST_RDATA_TX);
  assign rx_fire  = rx_valid & rx_ready;
  assign tx_fire  = tx_valid & tx_ready;

  assign htrans = (state_q == ST_AHB_ADDR) ? 2'b10 : 2'b00;
  assign hwrite = (state_q == ST_AHB_ADDR) & is_write_q;
  assign haddr  = addr_q;
  assign hwdata = wdata_q;
  assign hsize  = 3'b010;
  assign hburst = 3'b000;
  assign hprot  = 4'b0011;
  assign busy   = (state_q != ST_CMD);

  // Response byte mux: status byte in RESP, little-endian read data in RDATA_TX
  always_comb begin
    tx_data = 8'h00;
    if (state_q == ST_RESP) begin
      tx_data = resp_q;
    end else if (state_q == ST_RDATA_TX) begin
      case (cnt_q)
        2'd0:    tx_data = rdata_q[7:0];
        2'd1:    tx_data = rdata_q[15:8];
        2'd2:    tx_data = rdata_q[23:16];
        default: tx_data = rdata_q[31:24];
      endcase
    end
  end

  // Frame parser, AHB sequencing and response sequencing
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    is_write_d  = is_write_q;
    rd_follow_d = rd_follow_q;
    resp_d      = resp_q;
    case (state_q)
      ST_CMD: begin
        cnt_d = 2'd0;
        if (rx_fire) begin
          if (rx_data == CH_W) begin
            is_write_d = 1'b1;
            state_d    = ST_ADDR_RX;
          end else if (rx_data == CH_R) begin
            is_write_d = 1'b0;
            state_d    = ST_ADDR_RX;
          end else begin
            resp_d      = CH_Q;
            rd_follow_d = 1'b0;
            state_d     = ST_RESP;
          end
        end
      end
      ST_ADDR_RX: begin
        if (rx_fire) begin
          case (cnt_q)
            2'd0:    addr_d[7:0]   = rx_data;
            2'd1:    addr_d[15:8]  = rx_data;
            2'd2:    addr_d[23:16] = rx_data;
            default: addr_d[31:24] = rx_data;
          endcase
          // Word transfers only: low address bits are dropped silently
          addr_d[1:0] = 2'b00;
          cnt_d       = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            state_d = is_write_q ? ST_DATA_RX : ST_AHB_ADDR;
          end
        end
      end
      ST_DATA_RX: begin
        if (rx_fire) begin
          case (cnt_q)
            2'd0:    wdata_d[7:0]   = rx_data;
            2'd1:    wdata_d[15:8]  = rx_data;
            2'd2:    wdata_d[23:16] = rx_data;
            default: wdata_d[31:24] = rx_data;
          endcase
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            state_d = ST_AHB_ADDR;
          end
        end
      end
      ST_AHB_ADDR: begin
        if (hready) begin
          state_d = ST_AHB_DATA;
        end
      end
      ST_AHB_DATA: begin
        // hresp during a wait state is the first error cycle; only the final beat decides
        if (hready) begin
          rdata_d     = hrdata;
          resp_d      = hresp ? CH_E : CH_K;
          rd_follow_d = ~is_write_q & ~hresp;
          state_d     = ST_RESP;
        end
      end
      ST_RESP: begin
        if (tx_fire) begin
          cnt_d   = 2'd0;
          state_d = rd_follow_q ? ST_RDATA_TX : ST_CMD;
        end
      end
      ST_RDATA_TX: begin
        if (tx_fire) begin
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            state_d = ST_CMD;
          end
        end
      end
      default: state_d = ST_CMD;
    endcase

`ifdef AHB_UART_CMD_MASTER_TIMEOUT_EN
    to_cnt_d = 32'd0;
    if ((state_q == ST_ADDR_RX) || (state_q == ST_DATA_RX)) begin
      if (!rx_fire) begin
        if (to_cnt_q == TO_LAST) begin
          state_d = ST_CMD;
          cnt_d   = 2'd0;
        end else begin
          to_cnt_d = to_cnt_q + 32'd1;
        end
      end
    end
`endif
  end

  // State registers, asynchronously cleared at power-up reset
  always_ff @(posedge cpu_clk or negedge pwrup_rst_n) begin
    if (!pwrup_rst_n) begin
      state_q     <= ST_CMD;
      cnt_q       <= 2'd0;
      addr_q      <= 32'd0;
      wdata_q     <= 32'd0;
      rdata_q     <= 32'd0;
      is_write_q  <= 1'b0;
      rd_follow_q <= 1'b0;
      resp_q      <= 8'h00;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      is_write_q  <= is_write_d;
      rd_follow_q <= rd_follow_d;
      resp_q      <= resp_d;
    end
  end

`ifdef AHB_UART_CMD_MASTER_TIMEOUT_EN
  // Inter-byte idle counter
  always_ff @(posedge cpu_clk or negedge pwrup_rst_n) begin
    if (!pwrup_rst_n) begin
      to_cnt_q <= 32'd0;
    end else begin
      to_cnt_q <= to_cnt_d;
    end
  end
`endif

endmodule

// File: doc/ahb_uart_cmd_master.md
# ahb_uart_cmd_master

AHB-Lite master that turns a byte-stream command protocol into single-word AHB transfers, so a host on the board UART can peek and poke the SCR1 memory map (program RAM, UART registers, LED GPIO) without the debug TAP. It sits between the byte-level side of a UART receiver/transmitter pair and one AHB-Lite slave port or interconnect master input. It is the initiator counterpart of the memory-mapped slaves already in the SoC.

## Interface
Parameters:
- TIMEOUT_CYCLES, 1_000_000: inter-byte timeout in cpu_clk cycles. Used only with the timeout feature; minimum 2.

Ports:
- cpu_clk  in  1  clock; all logic on the rising edge.
- pwrup_rst_n  in  1  reset, asynchronous, active-low.
- rx_valid  in  1  received byte is valid this cycle.
- rx_data  in  8  received byte.
- rx_ready  out  1  block accepts a byte this cycle. A byte is consumed when rx_valid & rx_ready.
- tx_valid  out  1  response byte valid.
- tx_data  out  8  response byte.
- tx_ready  in  1  transmitter takes the byte when tx_valid & tx_ready.
- haddr  out  32  AHB address; bits [1:0] always 0.
- htrans  out  2  IDLE 2'b00 or NONSEQ 2'b10 only.
- hwrite  out  1  1 = write.
- hsize  out  3  constant 3'b010 (word).
- hburst  out  3  constant 3'b000 (SINGLE).
- hprot  out  4  constant 4'b0011.
- hwdata  out  32  write data, valid in the data phase.
- hrdata  in  32  read data.
- hready  in  1  transfer done / slave ready.
- hresp  in  1  1 = ERROR.
- busy  out  1  high in every state except CMD.

## Operation
- Frame formats (multi-byte fields are little-endian):
  - Write: 'W' (0x57), A0..A3, D0..D3. Response: 'K' (0x4B) on OKAY, 'E' (0x45) on ERROR.
  - Read: 'R' (0x52), A0..A3. Response: 'K' then hrdata bytes [7:0], [15:8], [23:16], [31:24]; on ERROR, a single 'E' only.
  - Any other byte in CMD: response '?' (0x3F), then return to CMD.
- States:
  - CMD: wait for a command byte.
  - ADDR_RX: collect 4 bytes with a 2-bit byte counter.
  - DATA_RX: collect 4 bytes (writes only).
  - AHB_ADDR, then AHB_DATA.
  - RESP: send the status byte.
  - RDATA_TX: send 4 bytes, then return to CMD.
- rx_ready is a combinational decode of the state: 1 in CMD, ADDR_RX and DATA_RX; 0 elsewhere.
- Address assembly: haddr = {A3, A2, A1, A0 & 8'hFC}. Low two bits are silently cleared.
- AHB_ADDR:
  - Drive htrans = NONSEQ plus haddr and hwrite.
  - Hold until a rising edge with hready = 1, then go to AHB_DATA.
- AHB_DATA:
  - Drive htrans = IDLE; hwdata holds the write word.
  - Wait for hready = 1, then capture hrdata and hresp into registers and go to RESP.
  - hresp = 1 with hready = 0 (first error cycle) is ignored; the decision uses hresp sampled with hready = 1.
- RESP and RDATA_TX:
  - tx_data is held stable while tx_valid = 1 and tx_ready = 0.
  - Advance on each handshake.
  - RESP goes to RDATA_TX only for an OKAY read; otherwise it goes to CMD.
- Values after reset:
  - state = CMD, htrans = 00, haddr = 0, hwrite = 0, hwdata = 0.
  - tx_valid = 0, tx_data = 0, busy = 0, rx_ready = 1.
  - The byte counter and the captured read-data register are 0.
- Reset mid-transfer aborts immediately. htrans returns to IDLE asynchronously and no response byte is sent.

## Timing
- Last frame byte accepted at edge E:
  - htrans = NONSEQ during cycle E to E+1.
  - With a zero-wait slave, the data phase is E+1 to E+2.
  - tx_valid = 1 from edge E+2.
- Each wait state (hready = 0) adds one cycle in the phase where it occurs.
- htrans = NONSEQ is never asserted for more than one transfer per frame. There are no back-to-back transfers.
- Minimum frame-to-frame gap: one CMD cycle after the last tx handshake.
- A command byte presented in the same cycle as the final tx handshake is not accepted, because rx_ready = 0 in that cycle.

## Configuration
- Macro: AHB_UART_CMD_MASTER_TIMEOUT_EN.
- When defined:
  - A counter restarts on each accepted byte.
  - If ADDR_RX or DATA_RX sees no accepted byte for TIMEOUT_CYCLES consecutive cycles, the state returns to CMD and the partial frame is discarded.
  - No response byte is sent.
- When undefined: no counter exists, and the parser waits indefinitely for the remaining frame bytes.

## Test plan
- Write, zero-wait slave: bytes 57 00 01 00 00 EF BE AD DE. Required: one NONSEQ cycle with haddr = 0x00000100, hwrite = 1; next cycle hwdata = 0xDEADBEEF; tx 4B.
- Read with 3 wait states: bytes 52 14 00 00 00, slave returns 0x00000061. Required: haddr = 0x14, hwrite = 0; tx bytes 4B 61 00 00 00; tx_valid starts 3 cycles later than in the zero-wait case.
- Two-cycle ERROR response on read of 0x0000_2000. Required: tx 45 only, then rx_ready = 1.
- Unknown byte 0x41. Required: tx 3F, no htrans activity; then a valid write frame executes normally. Also send address 0x103 and check haddr = 0x100.
- tx backpressure: hold tx_ready = 0 for 10 cycles during a read response. Required: tx_data stable, no bytes lost, order 4B d0 d1 d2 d3.
- Reset mid-transfer and timeout:
  - Assert pwrup_rst_n during AHB_DATA. Required: all outputs at reset values, no tx byte.
  - With the timeout macro defined and TIMEOUT_CYCLES = 16: send 52 00 and then stall. Required: return to CMD after 16 cycles.
